// File: rtl/mkio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mkio_pkg
// Description : Shared MKIO command-word field positions, broadcast address,
//               receive-writer state encoding and field-extraction helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mkio_pkg;

  // Command word layout: RT[15:11] T/R[10] SA[9:5] WC[4:0]
  localparam int unsigned c_RT_MSB = 15;
  localparam int unsigned c_RT_LSB = 11;
  localparam int unsigned c_TR_BIT = 10;
  localparam int unsigned c_SA_MSB = 9;
  localparam int unsigned c_SA_LSB = 5;
  localparam int unsigned c_WC_MSB = 4;
  localparam int unsigned c_WC_LSB = 0;

  // Remote-terminal address 31 addresses every terminal on the bus
  localparam logic [4:0] c_BCAST_ADDR = 5'd31;

  // Receive-writer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } mkio_state_t;

  // Field extraction from a 16-bit command word
  function automatic logic [4:0] cmd_rt(input logic [15:0] w);
    return w[c_RT_MSB:c_RT_LSB];
  endfunction

  function automatic logic cmd_tr(input logic [15:0] w);
    return w[c_TR_BIT];
  endfunction

  function automatic logic [4:0] cmd_sa(input logic [15:0] w);
    return w[c_SA_MSB:c_SA_LSB];
  endfunction

  function automatic logic [4:0] cmd_wc(input logic [15:0] w);
    return w[c_WC_MSB:c_WC_LSB];
  endfunction

endpackage : mkio_pkg
`default_nettype wire

// File: rtl/mkio_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : mkio_gap_timer
// Description : Inter-word gap counter. Counts enabled cycles since the last
//               clear and flags the cycle in which the count reaches
//               GAP_TIMEOUT. Held at zero while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module mkio_gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 1200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam int unsigned c_CW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(GAP_TIMEOUT - 1);

  logic [c_CW-1:0] r_cnt;

  // Gap count: clear wins, otherwise count while enabled, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Timeout fires when the current enabled cycle is the GAP_TIMEOUT-th one
  assign o_timeout = i_enable && !i_clear && (r_cnt == c_LAST);

endmodule : mkio_gap_timer
`default_nettype wire

// File: rtl/mkio_rx_writer.sv
`default_nettype none
// ============================================================================
// Module      : mkio_rx_writer
// Description : MKIO remote-terminal receive path. Recognises receive
//               commands addressed to this terminal's subaddress, writes the
//               following data words into the subaddress buffer and reports
//               message completion, abort and status-reply requests.
// Revision    : 1.0 - initial release
// ============================================================================
module mkio_rx_writer
  import mkio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned RT_ADDR     = 5,
  parameter int unsigned SUBADDR     = 1,
  parameter int unsigned GAP_TIMEOUT = 1200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_word,
  input  logic                  rx_valid,
  input  logic                  rx_is_cmd,
  input  logic                  rx_perr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] wraddress,
  output logic                  wren,
  output logic                  msg_done,
  output logic                  msg_err,
  output logic                  status_req,
  output logic                  busy
);

  localparam logic [4:0] c_RT_OWN = 5'(RT_ADDR);
  localparam logic [4:0] c_SA_OWN = 5'(SUBADDR);

  mkio_state_t           r_state;
  mkio_state_t           w_state_nxt;
  logic [4:0]            r_wc;
  logic                  r_bcast;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_last_idx;

  logic [15:0]           w_cmd;
  logic                  w_cmd_match;
  logic                  w_data_ok;
  logic                  w_timeout;
  logic                  w_gap_clear;
  logic                  w_gap_en;

  logic                  w_wr;
  logic                  w_last;
  logic                  w_done;
  logic                  w_err;
  logic                  w_status;
  logic                  w_load;

  // Command decode: a receive command for our subaddress, own or broadcast RT
  assign w_cmd       = rx_word[15:0];
  assign w_cmd_match = rx_valid && rx_is_cmd && !rx_perr &&
                       ((cmd_rt(w_cmd) == c_RT_OWN) || (cmd_rt(w_cmd) == c_BCAST_ADDR)) &&
                       !cmd_tr(w_cmd) && (cmd_sa(w_cmd) == c_SA_OWN);
  assign w_data_ok   = rx_valid && !rx_is_cmd && !rx_perr;

  // WC = 0 encodes 32 words; the 5-bit subtraction wraps to index 31 for it
  assign w_last_idx  = ADDR_WIDTH'(r_wc - 5'd1);

  assign w_gap_en    = (r_state == ST_RECV);
  assign w_gap_clear = w_load || w_wr;

  mkio_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_gap_clear),
    .i_enable  (w_gap_en),
    .o_timeout (w_timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a command in RECV is re-evaluated immediately as a new command
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_match) begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (rx_is_cmd) begin
            w_state_nxt = w_cmd_match ? ST_RECV : ST_IDLE;
          end else if (rx_perr) begin
            w_state_nxt = ST_IDLE;
          end else if (r_addr == w_last_idx) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered strobes and counter controls
  always_comb begin
    w_wr     = 1'b0;
    w_last   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_status = 1'b0;
    w_load   = w_cmd_match;
    if (r_state == ST_RECV) begin
      w_wr     = w_data_ok;
      w_last   = w_data_ok && (r_addr == w_last_idx);
      w_done   = w_last;
      w_status = w_last && !r_bcast;
      w_err    = (rx_valid && (rx_is_cmd || rx_perr)) || (!rx_valid && w_timeout);
    end
  end

  // Message context and address counter; cleared on each accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wc    <= '0;
      r_bcast <= 1'b0;
      r_addr  <= '0;
    end else if (w_load) begin
      r_wc    <= cmd_wc(w_cmd);
      r_bcast <= (cmd_rt(w_cmd) == c_BCAST_ADDR);
      r_addr  <= '0;
    end else if (w_last) begin
      r_addr  <= '0;
    end else if (w_wr) begin
      r_addr  <= r_addr + 1'b1;
    end
  end

  // Registered buffer-write port and message event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      wraddress  <= '0;
      wren       <= 1'b0;
      msg_done   <= 1'b0;
      msg_err    <= 1'b0;
      status_req <= 1'b0;
    end else begin
      wren       <= w_wr;
      msg_done   <= w_done;
      msg_err    <= w_err;
      status_req <= w_status;
      if (w_wr) begin
        data      <= rx_word;
        wraddress <= r_addr;
      end
    end
  end

  assign busy = (r_state == ST_RECV);

endmodule : mkio_rx_writer
`default_nettype wire
